// File: rtl/mem_pkg.sv
// Shared types and constants for the Mem stage and its lane-alignment helper.
package mem_pkg;

  // Memory operation carried from EX; OP_NONE marks a non-memory instruction.
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  // ExcCode values raised by this stage.
  localparam logic [4:0] EXC_ADEL = 5'd4;  // load address error
  localparam logic [4:0] EXC_ADES = 5'd5;  // store address error
  localparam logic [4:0] EXC_DBE  = 5'd7;  // data bus error (timeout)

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling shared by the bus path and a future cache path:
// request side builds byte enables and replicated store data, response side
// selects and extends the addressed lane of a read word.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     req_op,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_lane_wdata,
  input  mem_op_e     rsp_op,
  input  logic [1:0]  rsp_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte enables and store-data replication; loads read the whole word.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (which would infer a latch).
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    case (req_op)
      OP_SH: begin
        req_be         = 4'b0011 << req_lo;
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      OP_SB: begin
        req_be         = 4'b0001 << req_lo;
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane select by the low address bits, then sign or zero extension.
  always_comb begin
    byte_sel = rsp_rdata[{rsp_lo, 3'b000} +: 8];
    half_sel = rsp_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (rsp_op)
      OP_LB:   rsp_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  rsp_data = {24'd0, byte_sel};
      OP_LH:   rsp_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  rsp_data = {16'd0, half_sel};
      default: rsp_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline Mem stage acting as a variable-latency req/ack bus master.
// Non-memory and excepting instructions pass to WB in one cycle; memory ops
// stall the front of the pipe until the bus acks or the wait times out.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int unsigned DM_BYTES = 12288,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_err,
  input  logic [4:0]  ex_code,
  input  logic        flush,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic [4:0]  wb_code
);

  // A zero-width counter is illegal, so TIMEOUT=0 keeps a 1-bit dummy.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  mem_op_e     op, op_q;
  state_e      state, state_next;
  logic        live, is_mem, store, misalign, in_range;
  logic        exc, exc_live, start, timeout_hit;
  logic [4:0]  exc_code;
  logic [31:0] offset, addr_q, pc_q, lane_wdata, rsp_data;
  logic [4:0]  rd_q;
  logic [3:0]  lane_be;
  logic [CW-1:0] cnt;

  assign op       = mem_op_e'(ex_op);
  assign live     = ex_valid & ~flush;
  assign is_mem   = (op != OP_NONE);
  assign store    = is_store(op);
  assign misalign = is_misaligned(op, ex_addr[1:0]);
  // Offset into the window; addresses below DM_BASE wrap to huge values,
  // so one unsigned compare covers both bounds.
  assign offset   = ex_addr - DM_BASE;
  assign in_range = offset < DM_BYTES;

  // Exception priority: earlier stage, then alignment, then range.
  always_comb begin
    exc      = 1'b0;
    exc_code = 5'd0;
    if (ex_err) begin
      exc      = 1'b1;
      exc_code = ex_code;
    end else if (is_mem && (misalign || !in_range)) begin
      exc      = 1'b1;
      exc_code = store ? EXC_ADES : EXC_ADEL;
    end
  end

  assign exc_live    = live & exc;
  assign start       = (state == ST_IDLE) & live & is_mem & ~exc;
  assign timeout_hit = (TIMEOUT != 0) && (state == ST_BUSY) && (cnt == CNT_LAST);

  mem_lane_align u_lane (
    .req_op         (op),
    .req_lo         (ex_addr[1:0]),
    .req_wdata      (ex_wdata),
    .req_be         (lane_be),
    .req_lane_wdata (lane_wdata),
    .rsp_op         (op_q),
    .rsp_lo         (addr_q[1:0]),
    .rsp_rdata      (bus_rdata),
    .rsp_data       (rsp_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and stall; stall is forced low while reset is held.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_next = ST_BUSY;
        stall      = 1'b1;
      end
      ST_BUSY: begin
        if (bus_ack || timeout_hit) state_next = ST_IDLE;
        else                        stall      = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // Wait counter: zero on entry to BUSY, counts every BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset || state != ST_BUSY) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  // Request registers, captured on start and held for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      bus_we    <= 1'b0;
      op_q      <= OP_NONE;
      pc_q      <= 32'd0;
      rd_q      <= 5'd0;
    end else if (start) begin
      addr_q    <= ex_addr;
      bus_be    <= lane_be;
      bus_wdata <= lane_wdata;
      bus_we    <= store;
      op_q      <= op;
      pc_q      <= ex_pc;
      rd_q      <= ex_rd;
    end
  end

  assign bus_req  = (state == ST_BUSY);
  assign bus_addr = {addr_q[31:2], 2'b00};

  // WB registers: direct load from EX in IDLE, bubble while waiting,
  // access result on ack, bus error on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_pc    <= RESET_PC;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      wb_err   <= 1'b0;
      wb_code  <= 5'd0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= live;
        wb_pc    <= ex_pc;
        wb_rd    <= ex_rd;
        wb_data  <= ex_addr;
        wb_err   <= exc_live;
        wb_code  <= exc_live ? exc_code : 5'd0;
      end
    end else if (bus_ack) begin
      wb_valid <= 1'b1;
      wb_pc    <= pc_q;
      wb_rd    <= rd_q;
      wb_data  <= bus_we ? addr_q : rsp_data;
      wb_err   <= 1'b0;
      wb_code  <= 5'd0;
    end else if (timeout_hit) begin
      wb_valid <= 1'b1;
      wb_pc    <= pc_q;
      wb_rd    <= rd_q;
      wb_data  <= addr_q;
      wb_err   <= 1'b1;
      wb_code  <= EXC_DBE;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a vector table drives single
// instructions and answers the bus; a scoreboard checks every WB result.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_err, flush, stall;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata, ex_pc;
  logic [4:0]  ex_rd, ex_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_valid, wb_err;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd, wb_code;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DM_BASE  (32'h0000_0000),
    .DM_BYTES (12288),
    .TIMEOUT  (15),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_err(ex_err), .ex_code(ex_code), .flush(flush),
    .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .wb_code(wb_code)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [4:0]  code;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];

  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: wb_valid=1 pc=0x%08h with nothing expected", wb_pc);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check($sformatf("wb_pc@%08h", e.pc), wb_pc, e.pc);
        check($sformatf("wb_rd@%08h", e.pc), 32'(wb_rd), 32'(e.rd));
        check($sformatf("wb_err@%08h", e.pc), 32'(wb_err), 32'(e.err));
        check($sformatf("wb_code@%08h", e.pc), 32'(wb_code), 32'(e.code));
        if (e.chk_data) check($sformatf("wb_data@%08h", e.pc), wb_data, e.data);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err_in;
    logic [4:0]  code_in;
    logic        flush_in;
    int          ack_at;     // BUSY cycle that carries the ack; 0 = never
    logic        exp_req;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_bwdata;
    logic        exp_wbv;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [4:0]  exp_code;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic fill_table();
    //              op      addr          wdata         rdata         ei    cin    fl    ack rq    be       we    bwdata        wbv   data          er    code   chk
    vecs.push_back('{OP_LW,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 3, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LB,  32'h0000_0013, 32'h0,         32'h80FF_1234, 1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LBU, 32'h0000_0013, 32'h0,         32'h80FF_1234, 1'b0, 5'd0,  1'b0, 2, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LH,  32'h0000_0012, 32'h0,         32'h80FF_1234, 1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_80FF, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LHU, 32'h0000_0012, 32'h0,         32'h80FF_1234, 1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_80FF, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LB,  32'h0000_0010, 32'h0,         32'h80FF_1234, 1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_0034, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LH,  32'h0000_0010, 32'h0,         32'h1234_8001, 1'b0, 5'd0,  1'b0, 4, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'hFFFF_8001, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_SH,  32'h0000_0022, 32'h0000_ABCD, 32'h0,         1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1, 32'h0000_0022, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_SB,  32'h0000_0021, 32'h1234_56A5, 32'h0,         1'b0, 5'd0,  1'b0, 2, 1'b1, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h0000_0021, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_SW,  32'h0000_2FFC, 32'hCAFE_F00D, 32'h0,         1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_2FFC, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LB,  32'h0000_2FFF, 32'h0,         32'h7F00_0000, 1'b0, 5'd0,  1'b0, 1, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0000_007F, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_3002, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_3002, 1'b1, 5'd4, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_3000, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b1, 5'd4, 1'b1});
    vecs.push_back('{OP_SB,  32'h0000_4000, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_4000, 1'b1, 5'd5, 1'b1});
    vecs.push_back('{OP_SH,  32'h0000_0021, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_0021, 1'b1, 5'd5, 1'b1});
    vecs.push_back('{OP_SW,  32'h0000_0002, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b1, 5'd5, 1'b1});
    vecs.push_back('{OP_NONE,32'h1234_5678, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 5'd0, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_0010, 32'h0,         32'h0,         1'b1, 5'd10, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 5'd10, 1'b1});
    vecs.push_back('{OP_LW,  32'h0000_0010, 32'h0,         32'h0,         1'b0, 5'd0,  1'b1, 0, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 5'd0, 1'b0});
    vecs.push_back('{OP_LW,  32'h0000_0040, 32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 0, 1'b1, 4'b1111, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 5'd7, 1'b0});
  endtask

  // Drive one instruction at a negedge, answer the bus, count stall and
  // request cycles until the stage lets EX advance.
  task automatic apply_vec(input vec_t v, input int idx);
    int  reqs, stalls, exp_busy;
    bit  done;
    logic [31:0] pc;
    pc       = 32'h100 + 32'(idx) * 4;
    ex_valid = 1'b1;
    ex_op    = v.op;
    ex_addr  = v.addr;
    ex_wdata = v.wdata;
    ex_pc    = pc;
    ex_rd    = 5'(idx + 1);
    ex_err   = v.err_in;
    ex_code  = v.code_in;
    flush    = v.flush_in;
    if (v.exp_wbv)
      sb.push_back('{pc, 5'(idx + 1), v.exp_data, v.exp_err, v.exp_code, v.chk_data});
    exp_busy = !v.exp_req ? 0 : ((v.ack_at == 0) ? 15 : v.ack_at);
    reqs   = 0;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          check($sformatf("v%0d_bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d_bus_be", idx), 32'(bus_be), 32'(v.exp_be));
          check($sformatf("v%0d_bus_we", idx), 32'(bus_we), 32'(v.exp_we));
          if (v.exp_we) check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_bwdata);
        end
      end
      bus_ack   = bus_req && (reqs == v.ack_at);
      bus_rdata = bus_ack ? v.rdata : 32'h5A5A_5A5A;
      #1;
      if (stall) stalls++;
      else       done = 1'b1;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    flush   = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL v%0d_complete: stall still high after 64 cycles, expected release", idx);
    end
    check($sformatf("v%0d_req_cycles", idx), 32'(reqs), 32'(exp_busy));
    check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a valid load presented: stall must stay low.
    reset = 1'b1; ex_valid = 1'b1; ex_op = OP_LW; ex_addr = 32'h10; ex_wdata = 32'h0;
    ex_pc = 32'h0; ex_rd = 5'd0; ex_err = 1'b0; ex_code = 5'd0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_pc", wb_pc, 32'h0000_3000);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_code", 32'(wb_code), 32'd0);
    reset = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE;
    @(negedge clk);

    fill_table();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
    ex_valid = 1'b0; ex_op = OP_NONE;
    @(negedge clk);

    // flush arriving while BUSY must not kill the in-flight load.
    sb.push_back('{32'h800, 5'd7, 32'h1122_3344, 1'b0, 5'd0, 1'b1});
    ex_valid = 1'b1; ex_op = OP_LW; ex_addr = 32'h14; ex_pc = 32'h800; ex_rd = 5'd7;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    #1 check("flush_busy_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE;
    @(negedge clk);

    // Reset in the 2nd BUSY cycle, then a stray ack while IDLE.
    ex_valid = 1'b1; ex_op = OP_LW; ex_addr = 32'h10; ex_pc = 32'h900; ex_rd = 5'd3;
    @(negedge clk);
    #1 check("rstbusy_req_c1", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rstbusy_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("rstbusy_bus_req", 32'(bus_req), 32'd0);
    check("rstbusy_wb_valid", 32'(wb_valid), 32'd0);
    check("rstbusy_wb_pc", wb_pc, 32'h0000_3000);
    reset = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_ack_bus_req", 32'(bus_req), 32'd0);
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised pipeline Mem stage that replaces the single-cycle data-memory stage with a variable-latency bus master. It sits between the EX/Mem and Mem/WB pipeline registers. It generates byte enables and lane-aligned store data, and detects alignment and range exceptions. It drives a req/ack data bus, stalls the pipeline until the access completes or times out, and registers the extended result toward WB.

## Interface
Parameters:
- DM_BASE, 32'h0000_0000: first byte address of the data memory window.
- DM_BYTES, 12288: window size in bytes; must be a multiple of 4.
- TIMEOUT, 15: max cycles waiting for bus_ack; 0 disables the timeout.
- RESET_PC, 32'h0000_3000: wb_pc value after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ex_valid  in  1  instruction present from EX.
- ex_op  in  4  memory op: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
- ex_addr  in  32  ALU result; this is the effective address for memory ops.
- ex_wdata  in  32  store data, already forwarded.
- ex_pc  in  32  instruction PC.
- ex_rd  in  5  destination register.
- ex_err  in  1  earlier-stage exception pending.
- ex_code  in  5  earlier-stage ExcCode.
- flush  in  1  kill the instruction currently at the EX-side inputs.
- stall  out  1  freeze IF..EX stages this cycle.
- bus_req  out  1  bus request.
- bus_we  out  1  write request.
- bus_addr  out  32  word-aligned address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completion, single-cycle pulse.
- bus_rdata  in  32  read data, valid with bus_ack.
- wb_valid  out  1  WB slot holds a live instruction.
- wb_pc, wb_rd  out  32/5  passthrough.
- wb_data  out  32  extended load data, or ex_addr for non-memory ops.
- wb_err, wb_code  out  1/5  exception flag and ExcCode.

## Operation
- FSM states: IDLE, BUSY.
- start condition: IDLE & ex_valid & !flush & ex_op≠NONE & !ex_err & !misalign & in_range.
- misalign:
  - LW/SW: addr[1:0]≠0.
  - LH/LHU/SH: addr[0]=1.
  - Misaligned load raises code 4 (AdEL); misaligned store raises code 5 (AdES).
- in_range: DM_BASE ≤ addr ≤ DM_BASE+DM_BYTES−1. Out of range raises AdEL/AdES the same way.
- Exception priority: ex_err passes through first, then misalign, then range. An excepting instruction never issues a bus request.
- IDLE with start: latch bus_addr={addr[31:2],2'b00}, bus_be, bus_wdata, bus_we, load op, pc and rd. Go to BUSY and clear the timeout counter.
- IDLE without start: load the WB registers directly.
  - wb_valid = ex_valid & !flush.
  - wb_data = ex_addr.
  - Error fields as computed above.
- Byte enables:
  - SW: 1111.
  - SH: 0011<<addr[1:0].
  - SB: 0001<<addr[1:0].
- Store data: SH replicates wdata[15:0] into both halves; SB replicates wdata[7:0] into all four bytes.
- Load extension: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. Stores write wb_data = ex_addr.
- BUSY:
  - On bus_ack: load the WB registers (wb_valid=1, data per op), drop bus_req, go to IDLE.
  - On timeout (counter reaches TIMEOUT−1 without ack): wb_err=1, wb_code=7 (DBE), drop bus_req, go to IDLE.
  - flush is ignored in BUSY: the in-flight instruction is older than anything being flushed.
- stall = (IDLE & start) | (BUSY & !bus_ack & !timeout_hit).

## Timing
- Non-memory or excepting instruction: 1-cycle latency to the WB registers. stall stays 0.
- Memory op:
  - Cycle 0: start; stall=1.
  - Cycle 1 onward: bus_req=1 and bus_addr/be/we/wdata are held stable.
  - Ack in cycle k: stall=0 that cycle; the WB registers update at the end of cycle k, and EX advances on the same edge.
  - Best-case total is 2 cycles.
- bus_req is registered and never depends combinationally on bus_ack.
- bus_ack while IDLE is ignored.
- Reset (any cycle, including mid-BUSY):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - wb_valid=0, wb_pc=RESET_PC, wb_rd=0, wb_data=0, wb_err=0, wb_code=0.
  - stall=0 while reset is high.
- Timeout counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the stage waits forever.

## Structure
- Shared package mem_pkg holds:
  - the ex_op encoding enum;
  - ExcCode constants AdEL=4, AdES=5, DBE=7;
  - the FSM state type.
- Sub-module mem_lane_align: combinational logic for byte-enable generation, store replication and load extension. It is reused by a future cache path.

## Test plan
- LW addr 0x10, ack 3 cycles after req, rdata 0xDEADBEEF -> stall high for 3 cycles, then wb_data=0xDEADBEEF, wb_valid=1, bus_be=1111.
- LB addr 0x13, rdata 0x80FF1234 -> bus_be=1111 read, wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x22, wdata 0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
- LW addr 0x3002 -> no bus_req, wb_err=1, wb_code=4, stall=0. SB addr 0x4000 with DM_BYTES=12288 -> wb_code=5.
- No ack with TIMEOUT=15 -> bus_req high for exactly 15 cycles, then wb_err=1, wb_code=7, stall drops.
- Reset asserted in the 2nd BUSY cycle -> next cycle bus_req=0 and wb_valid=0. A later ack is ignored.
